// File: rtl/clk_monitor.sv
// clk_monitor: measures the frequency of an asynchronous clock against the
// free-running sys_clock. After the monitored clock reports lock and stays
// locked for SETTLE cycles, rising edges are counted over windows of WINDOW
// reference cycles. Each completed count is published and checked against
// [min_count, max_count]. A sticky fault records the first problem seen.
`timescale 1ns/1ps

module clk_monitor #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 64,
    parameter int CNT_W  = 16
) (
    input  logic             sys_clock,
    input  logic             resetn,
    input  logic             mon_clk,
    input  logic             mon_locked,
    input  logic [CNT_W-1:0] min_count,
    input  logic [CNT_W-1:0] max_count,
    input  logic             clear,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             stable,
    output logic             fault,
    output logic [1:0]       fault_code
);

    // Counter widths; the settle counter needs at least one bit even for SETTLE=1.
    localparam int WIN_W = $clog2(WINDOW);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    localparam logic [SET_W-1:0] SET_ZERO = {SET_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_SLOW = 2'b01;
    localparam logic [1:0] CODE_FAST = 2'b10;
    localparam logic [1:0] CODE_LOCK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Add one detected edge, holding at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc
    );
        logic [CNT_W-1:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Grade a finished window; an inverted limit pair always reads as too slow.
    function automatic logic [1:0] classify(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        logic [1:0] code;
        if (lo > hi) begin
            code = CODE_SLOW;
        end else if (cnt < lo) begin
            code = CODE_SLOW;
        end else if (cnt > hi) begin
            code = CODE_FAST;
        end else begin
            code = CODE_NONE;
        end
        return code;
    endfunction

    // Synchroniser stages for the monitored clock and its lock indication.
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic lock_s1_q, lock_s2_q;
    logic edge_s;

    // Measurement state.
    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] window_total_s;

    // Registered outputs.
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             count_valid_q, count_valid_d;
    logic             stable_q, stable_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;

    // Fault raised this cycle, if any.
    logic             new_fault_s;
    logic [1:0]       new_code_s;

    // Two-flop synchronisers; the extra clock stage gives the rising-edge detector.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_s3_q  <= 1'b0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            clk_s1_q  <= mon_clk;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            lock_s1_q <= mon_locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign edge_s = clk_s2_q & ~clk_s3_q;

    // Running edge total for the current cycle, including an edge seen right now.
    assign window_total_s = sat_inc(edge_cnt_q, edge_s);

    // Next-state logic: settle qualification, window bookkeeping and fault capture.
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        win_cnt_d     = win_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        count_out_d   = count_out_q;
        count_valid_d = 1'b0;
        new_fault_s   = 1'b0;
        new_code_s    = CODE_NONE;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;

        case (state_q)
            ST_IDLE: begin
                settle_cnt_d = SET_ZERO;
                win_cnt_d    = WIN_ZERO;
                edge_cnt_d   = CNT_ZERO;
                if (lock_s2_q) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                win_cnt_d  = WIN_ZERO;
                edge_cnt_d = CNT_ZERO;
                if (!lock_s2_q) begin
                    // Lock lost before measuring started: silently start over.
                    state_d      = ST_IDLE;
                    settle_cnt_d = SET_ZERO;
                end else if (settle_cnt_q == SET_LAST) begin
                    state_d      = ST_RUN;
                    settle_cnt_d = SET_ZERO;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s2_q) begin
                    // Partial window is abandoned; no count is published.
                    state_d     = ST_IDLE;
                    win_cnt_d   = WIN_ZERO;
                    edge_cnt_d  = CNT_ZERO;
                    new_fault_s = 1'b1;
                    new_code_s  = CODE_LOCK;
                end else if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d     = WIN_ZERO;
                    edge_cnt_d    = CNT_ZERO;
                    count_out_d   = window_total_s;
                    count_valid_d = 1'b1;
                    new_code_s    = classify(window_total_s, min_count, max_count);
                    new_fault_s   = (new_code_s != CODE_NONE);
                end else begin
                    win_cnt_d  = win_cnt_q + WIN_ONE;
                    edge_cnt_d = window_total_s;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                settle_cnt_d = SET_ZERO;
                win_cnt_d    = WIN_ZERO;
                edge_cnt_d   = CNT_ZERO;
            end
        endcase

        // Sticky fault: the first code is kept; a clear colliding with a new fault
        // lets the new fault through.
        if (new_fault_s) begin
            if (fault_q && !clear) begin
                fault_d      = fault_q;
                fault_code_d = fault_code_q;
            end else begin
                fault_d      = 1'b1;
                fault_code_d = new_code_s;
            end
        end else if (clear) begin
            fault_d      = 1'b0;
            fault_code_d = CODE_NONE;
        end else begin
            fault_d      = fault_q;
            fault_code_d = fault_code_q;
        end

        stable_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= SET_ZERO;
            win_cnt_q     <= WIN_ZERO;
            edge_cnt_q    <= CNT_ZERO;
            count_out_q   <= CNT_ZERO;
            count_valid_q <= 1'b0;
            stable_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= CODE_NONE;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            win_cnt_q     <= win_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            stable_q      <= stable_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign stable      = stable_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: random and directed clock/lock/limit scenarios,
// a reference model that derives window counts from sampled waveforms,
// and a queue-based scoreboard popped whenever count_valid is seen.
`timescale 1ns/100ps

module tb_clk_monitor;

    localparam int WINDOW  = 100;
    localparam int SETTLE  = 16;
    localparam int CNT_W   = 16;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             sys_clock = 1'b0;
    logic             resetn    = 1'b0;
    logic             mon_locked = 1'b0;
    logic             clear     = 1'b0;
    logic             mon_base  = 1'b0;
    logic             glitch    = 1'b0;
    logic             mon_clk;
    logic [CNT_W-1:0] min_count = 16'd18;
    logic [CNT_W-1:0] max_count = 16'd22;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             stable;
    logic             fault;
    logic [1:0]       fault_code;

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;
    bit  mon_run = 1'b1;
    int  half_lo = 25;
    int  half_hi = 25;

    assign mon_clk = mon_base ^ glitch;

    clk_monitor #(
        .WINDOW(WINDOW),
        .SETTLE(SETTLE),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clock  (sys_clock),
        .resetn     (resetn),
        .mon_clk    (mon_clk),
        .mon_locked (mon_locked),
        .min_count  (min_count),
        .max_count  (max_count),
        .clear      (clear),
        .count_out  (count_out),
        .count_valid(count_valid),
        .stable     (stable),
        .fault      (fault),
        .fault_code (fault_code)
    );

    // 100 MHz reference clock, rising edges at 5, 15, 25 ... ns.
    always #5 sys_clock = ~sys_clock;

    // Monitored clock; transitions sit at x.3 ns so they never coincide with a sys edge.
    initial begin
        #0.3;
        forever begin
            if (mon_run) begin
                #(half_lo) mon_base = 1'b1;
                #(half_hi) mon_base = 1'b0;
            end else begin
                #1;
            end
        end
    end

    // ---------------- reference model ----------------
    int exp_q[$];
    int run_len = 0;
    int acc = 0;
    bit c0, c1, c2, l0, l1;
    bit m_cv = 1'b0, m_stable = 1'b0, m_fault = 1'b0;
    int m_code = 0, m_count = 0;
    bit lk, rise, was_run;
    int pos, cnt, nc;

    // A sample taken at edge k is acted on at edge k+2. The monitor is measuring
    // once lock has been seen on SETTLE+1 consecutive edges; window slots are
    // numbered from the first edge after that.
    always @(posedge sys_clock) begin
        if (!resetn) begin
            run_len = 0; acc = 0;
            c0 = 1'b0; c1 = 1'b0; c2 = 1'b0; l0 = 1'b0; l1 = 1'b0;
            m_cv = 1'b0; m_stable = 1'b0; m_fault = 1'b0; m_code = 0; m_count = 0;
        end else begin
            lk      = l1;
            rise    = c1 & ~c2;
            was_run = (run_len >= SETTLE + 1);
            nc      = 0;
            m_cv    = 1'b0;
            if (lk) begin
                run_len = run_len + 1;
                if (was_run) begin
                    pos = (run_len - SETTLE - 2) % WINDOW;
                    acc = acc + int'(rise);
                    if (pos == WINDOW - 1) begin
                        cnt = (acc > CNT_SAT) ? CNT_SAT : acc;
                        exp_q.push_back(cnt);
                        m_count = cnt;
                        m_cv = 1'b1;
                        if ((min_count > max_count) || (cnt < int'(min_count))) nc = 1;
                        else if (cnt > int'(max_count)) nc = 2;
                        acc = 0;
                    end
                end else begin
                    acc = 0;
                end
            end else begin
                if (was_run) nc = 3;
                run_len = 0;
                acc = 0;
            end
            if (nc != 0) begin
                if (!(m_fault && !clear)) begin
                    m_fault = 1'b1;
                    m_code  = nc;
                end
            end else if (clear) begin
                m_fault = 1'b0;
                m_code  = 0;
            end
            m_stable = (run_len >= SETTLE + 1);
            c2 = c1; c1 = c0; c0 = mon_clk;
            l1 = l0; l0 = mon_locked;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    int popped;
    always @(negedge sys_clock) begin
        if (mon_en) begin
            if (count_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL window_count: actual=%0d expected=<no window due> at %0t",
                             count_out, $time);
                end else begin
                    popped = exp_q.pop_front();
                    chk("window_count", int'(count_out), popped);
                end
            end
            chk("count_valid", int'(count_valid), int'(m_cv));
            chk("stable", int'(stable), int'(m_stable));
            chk("fault", int'(fault), int'(m_fault));
            chk("fault_code", int'(fault_code), m_code);
            chk("count_out", int'(count_out), m_count);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    // Dip the high phase of an 80 ns mon_clk across exactly one sys edge.
    task automatic inject_glitch();
        @(posedge mon_base);
        @(posedge sys_clock);
        #8.5 glitch = 1'b1;
        #3   glitch = 1'b0;
        @(negedge sys_clock);
    endtask

    initial begin
        #1 mon_en = 1'b1;
        cycles(3);
        resetn = 1'b1;
        cycles(2);

        // nominal 50 ns clock, limits 18/22
        mon_locked = 1'b1;
        cycles(SETTLE + 2 + 3 * WINDOW + 10);

        // too fast, then slow: first code sticks
        half_lo = 12; half_hi = 13;
        cycles(2 * WINDOW + 20);
        half_lo = 50; half_hi = 50;
        cycles(2 * WINDOW);

        // stopped clock with clears
        pulse_clear();
        mon_run = 1'b0;
        cycles(WINDOW + 50);
        pulse_clear();
        cycles(2 * WINDOW);

        // lock loss mid-window and relock
        mon_run = 1'b1; half_lo = 25; half_hi = 25;
        pulse_clear();
        cycles(WINDOW + 40);
        mon_locked = 1'b0;
        cycles(5);
        mon_locked = 1'b1;
        cycles(SETTLE + 2 * WINDOW + 20);

        // glitch on an 80 ns clock
        pulse_clear();
        half_lo = 40; half_hi = 40;
        min_count = 16'd11; max_count = 16'd13;
        cycles(2 * WINDOW);
        inject_glitch();
        cycles(2 * WINDOW);

        // one-cycle reset mid-window
        half_lo = 25; half_hi = 25;
        min_count = 16'd18; max_count = 16'd22;
        cycles(WINDOW + 37);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        cycles(SETTLE + 2 * WINDOW + 30);

        // inverted limits
        min_count = 16'd30; max_count = 16'd10;
        pulse_clear();
        cycles(2 * WINDOW + 10);

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            half_lo   = int'($urandom_range(8, 40));
            half_hi   = int'($urandom_range(8, 40));
            min_count = CNT_W'($urandom_range(0, 40));
            max_count = CNT_W'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) pulse_clear();
            cycles(int'($urandom_range(50, 300)));
            case ($urandom_range(0, 5))
                0: begin
                    mon_locked = 1'b0;
                    cycles(int'($urandom_range(1, 4)));
                    mon_locked = 1'b1;
                end
                1: begin
                    resetn = 1'b0;
                    cycles(1);
                    resetn = 1'b1;
                end
                2: mon_run = ~mon_run;
                default: mon_run = 1'b1;
            endcase
        end
        mon_run = 1'b1;
        cycles(SETTLE + WINDOW + 20);

        @(posedge sys_clock);
        @(negedge sys_clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_windows: actual=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
